// File: rtl/uart1_rx_pkg.sv
// Shared definitions for the uart1_rx receiver: frame geometry and FSM states.
package uart1_rx_pkg;

    localparam int DATA_BITS = 8;
    localparam int IDX_BITS  = $clog2(DATA_BITS);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

endpackage

// File: rtl/uart1_rx_if.sv
// Serial line plus byte/interrupt status of the uart1_rx receiver.
interface uart1_rx_if;
    import uart1_rx_pkg::*;

    logic                 rx;
    logic                 interrupt_clear;
    logic [DATA_BITS-1:0] data;
    logic                 interrupt;

    // The receiver is the slave; whoever drives the line and services the interrupt is the master.
    modport master (
        output rx,
        output interrupt_clear,
        input  data,
        input  interrupt
    );

    modport slave (
        input  rx,
        input  interrupt_clear,
        output data,
        output interrupt
    );

endinterface

// File: rtl/uart1_rx_sync2.sv
// Two-flop synchronizer for the asynchronous rx line; resets to the idle level (1).
module uart1_rx_sync2 (
    input  logic clk,
    input  logic nreset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart1_rx.sv
// 8N1 UART receiver: start bit checked at mid-bit, data and stop bits sampled one bit period later.
module uart1_rx
    import uart1_rx_pkg::*;
#(
    parameter int CLOCK_DIV          = 8,
    parameter int CLOCK_COUNTER_BITS = 4
) (
    input  logic       clk,
    input  logic       nreset,
    uart1_rx_if.slave  bus
);

    localparam logic [CLOCK_COUNTER_BITS-1:0] HALF_LAST = CLOCK_COUNTER_BITS'(CLOCK_DIV / 2 - 1);
    localparam logic [CLOCK_COUNTER_BITS-1:0] FULL_LAST = CLOCK_COUNTER_BITS'(CLOCK_DIV - 1);
    localparam logic [IDX_BITS-1:0]           IDX_LAST  = IDX_BITS'(DATA_BITS - 1);

    rx_state_t                     state;
    logic [CLOCK_COUNTER_BITS-1:0] cnt;
    logic [IDX_BITS-1:0]           idx;
    logic [DATA_BITS-1:0]          shift;
    logic [DATA_BITS-1:0]          data_q;
    logic                          interrupt_q;
    logic                          rx_s;

    uart1_rx_sync2 u_sync (
        .clk    (clk),
        .nreset (nreset),
        .d      (bus.rx),
        .q      (rx_s)
    );

    // The clear is applied first so that a set later in the same cycle overrides it.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shift       <= '0;
            data_q      <= '0;
            interrupt_q <= 1'b0;
        end else begin
            if (bus.interrupt_clear) begin
                interrupt_q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    if (!rx_s) begin
                        state <= START;
                    end
                end

                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt   <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == FULL_LAST) begin
                        cnt   <= '0;
                        shift <= {rx_s, shift[DATA_BITS-1:1]};
                        if (idx == IDX_LAST) begin
                            idx   <= '0;
                            state <= STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                STOP: begin
                    // Leaving at mid-stop-bit lets a back-to-back start edge be seen at once.
                    if (cnt == FULL_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                        if (rx_s) begin
                            data_q      <= shift;
                            interrupt_q <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    cnt   <= '0;
                    idx   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.data      = data_q;
    assign bus.interrupt = interrupt_q;

endmodule

// File: tb/tb_uart1_rx.sv
// Self-checking bench for uart1_rx: table of frames fed through a scoreboard plus hand-written corner cases.
module tb_uart1_rx;

    localparam int CLK_PER_BIT = 8;

    typedef struct {
        logic [7:0] value;
        logic       stop_bit;
        logic       clr_before;
        logic       clr_at_set;
        logic [7:0] exp_data;
        logic       exp_int;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       intr;
    } exp_t;

    logic clk = 1'b0;
    logic nreset;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t vectors[6];

    uart1_rx_if bus ();

    uart1_rx #(
        .CLOCK_DIV          (CLK_PER_BIT),
        .CLOCK_COUNTER_BITS (4)
    ) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic checkValue(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%02h required=0x%02h", name, actual, expected);
        end
    endtask

    // Drives one frame starting at the current negedge; returns 10 bit periods later, at a negedge.
    task automatic sendFrame(input logic [7:0] value, input logic stop_bit, input logic clr_at_set);
        bus.rx = 1'b0;
        repeat (CLK_PER_BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx = value[i];
            repeat (CLK_PER_BIT) @(negedge clk);
        end
        bus.rx = stop_bit;
        if (clr_at_set) begin
            repeat (CLK_PER_BIT - 2) @(negedge clk);
            bus.interrupt_clear = 1'b1;
            @(negedge clk);
            bus.interrupt_clear = 1'b0;
            @(negedge clk);
        end else begin
            repeat (CLK_PER_BIT) @(negedge clk);
        end
        bus.rx = 1'b1;
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        if (v.clr_before) begin
            @(negedge clk);
            bus.interrupt_clear = 1'b1;
            @(negedge clk);
            bus.interrupt_clear = 1'b0;
        end
        e.data = v.exp_data;
        e.intr = v.exp_int;
        sb.push_back(e);
        sendFrame(v.value, v.stop_bit, v.clr_at_set);
        if (!v.stop_bit) begin
            repeat (2 * CLK_PER_BIT) @(negedge clk);
        end
    endtask

    task automatic checkOutput(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s actual=empty_scoreboard required=entry", name);
        end else begin
            e = sb.pop_front();
            checkValue({name, "_data"}, bus.data, e.data);
            checkValue({name, "_int"}, {7'd0, bus.interrupt}, {7'd0, e.intr});
        end
    endtask

    initial begin
        vectors[0] = '{8'h33, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0};
        vectors[1] = '{8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
        vectors[2] = '{8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b1};
        vectors[3] = '{8'h81, 1'b1, 1'b1, 1'b1, 8'h81, 1'b1};
        vectors[4] = '{8'h3C, 1'b0, 1'b1, 1'b0, 8'h81, 1'b0};
        vectors[5] = '{8'hC3, 1'b1, 1'b0, 1'b0, 8'hC3, 1'b1};

        nreset              = 1'b0;
        bus.rx              = 1'b1;
        bus.interrupt_clear = 1'b0;
        repeat (4) @(negedge clk);
        checkValue("reset_data", bus.data, 8'h00);
        checkValue("reset_int", {7'd0, bus.interrupt}, 8'h00);
        nreset = 1'b1;
        repeat (4) @(negedge clk);
        checkValue("post_reset_int", {7'd0, bus.interrupt}, 8'h00);

        // Result must appear exactly on the 79th rising edge after the rx fall.
        fork
            sendFrame(8'h5A, 1'b1, 1'b0);
            begin
                repeat (78) @(posedge clk);
                #1 checkValue("latency_before_int", {7'd0, bus.interrupt}, 8'h00);
                @(posedge clk);
                #1 checkValue("latency_at_int", {7'd0, bus.interrupt}, 8'h01);
                checkValue("latency_at_data", bus.data, 8'h5A);
            end
        join
        repeat (20) @(negedge clk);
        checkValue("int_sticky", {7'd0, bus.interrupt}, 8'h01);

        bus.interrupt_clear = 1'b1;
        @(posedge clk);
        #1 checkValue("clear_int", {7'd0, bus.interrupt}, 8'h00);
        checkValue("clear_data", bus.data, 8'h5A);
        @(negedge clk);
        bus.interrupt_clear = 1'b0;

        bus.rx = 1'b0;
        repeat (2) @(negedge clk);
        bus.rx = 1'b1;
        repeat (20) @(negedge clk);
        checkValue("glitch_int", {7'd0, bus.interrupt}, 8'h00);
        checkValue("glitch_data", bus.data, 8'h5A);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vectors[i]);
            checkOutput($sformatf("vec%0d", i));
        end

        // Abort a frame mid data bit 4 with reset; the line is idle before release.
        bus.rx = 1'b0;
        repeat (CLK_PER_BIT * 5 + CLK_PER_BIT / 2) @(negedge clk);
        nreset = 1'b0;
        #1 checkValue("midframe_reset_data", bus.data, 8'h00);
        checkValue("midframe_reset_int", {7'd0, bus.interrupt}, 8'h00);
        bus.rx = 1'b1;
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        repeat (20) @(negedge clk);
        checkValue("after_abort_data", bus.data, 8'h00);
        checkValue("after_abort_int", {7'd0, bus.interrupt}, 8'h00);

        applyStimulus('{8'hA5, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1});
        checkOutput("after_reset_frame");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
